if_fetch_ctrl: RTL

Fetch-stage sequencer between `pc_reg` and the instruction SRAM port. It decides when `pc_reg` advances, issues one instruction request at a time, and buffers one returned instruction when ID stalls. It also holds a branch redirect until `pc_reg` can consume it, and drops any in-flight fetch made stale by a redirect.

---
 rtl/if_fetch_ctrl_if.sv | 20 ++
 rtl/if_fetch_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Instruction SRAM request/response port seen by the fetch sequencer.
interface if_fetch_ctrl_if #(
  parameter int unsigned RegW = 32
) ();
  logic            inst_req;
  logic [RegW-1:0] inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [31:0]     inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: paces pc_reg, issues one SRAM fetch at a time,
// buffers one word for a stalled ID and squashes fetches made stale by redirects.
module if_fetch_ctrl #(
  parameter int unsigned RegW = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [32:0]           jbr_bus_i,
  output logic [32:0]           jbr_bus_o,
  output logic                  pc_allow_nxt_o,
  input  logic [RegW-1:0]       pc_i,
  if_fetch_ctrl_if.master       inst_bus,
  input  logic                  id_allow_in_i,
  output logic                  if_to_id_valid_o,
  output logic [RegW-1:0]       if_pc_o,
  output logic [31:0]           if_inst_o
);

  typedef enum logic [1:0] {
    ADV  = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e          state;
  logic            redir_vld;
  logic [31:0]     redir_tgt;
  logic            discard;
  logic [RegW-1:0] req_pc;
  logic [RegW-1:0] buf_pc;
  logic [31:0]     buf_inst;

  logic            live_taken;
  logic [31:0]     live_tgt;
  logic            data_ok;
  logic            bypass_hit;

  assign live_taken = jbr_bus_i[32];
  assign live_tgt   = jbr_bus_i[31:0];
  assign data_ok    = inst_bus.inst_data_ok;
  assign bypass_hit = (state == WAIT) && data_ok && !discard && id_allow_in_i;

  // Every externally visible output is forced to its reset value while rst_i is high.
  always_comb begin
    jbr_bus_o          = '0;
    pc_allow_nxt_o     = 1'b0;
    inst_bus.inst_req  = 1'b0;
    inst_bus.inst_addr = '0;
    if_to_id_valid_o   = 1'b0;
    if_pc_o            = '0;
    if_inst_o          = '0;
    if (!rst_i) begin
      jbr_bus_o          = {redir_vld | live_taken, live_taken ? live_tgt : redir_tgt};
      pc_allow_nxt_o     = (state == ADV);
      inst_bus.inst_req  = (state == REQ);
      inst_bus.inst_addr = (state == REQ) ? pc_i : '0;
      if_to_id_valid_o   = !live_taken && (bypass_hit || (state == HOLD));
      if_pc_o            = (state == HOLD) ? buf_pc : req_pc;
      if_inst_o          = (state == HOLD) ? buf_inst : inst_bus.inst_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ADV;
      redir_vld <= 1'b0;
      redir_tgt <= '0;
      discard   <= 1'b0;
      req_pc    <= '0;
      buf_pc    <= '0;
      buf_inst  <= '0;
    end else begin
      // Outside ADV a redirect cannot reach pc_reg yet, so park it; newest wins.
      if (live_taken && (state != ADV)) begin
        redir_vld <= 1'b1;
        redir_tgt <= live_tgt;
      end
      unique case (state)
        ADV: begin
          redir_vld <= 1'b0;
          state     <= REQ;
        end
        REQ: begin
          if (live_taken) discard <= 1'b1;
          if (inst_bus.inst_addr_ok) begin
            req_pc <= pc_i;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (data_ok) begin
            discard <= 1'b0;
            if (discard || live_taken || id_allow_in_i) begin
              state <= ADV;
            end else begin
              buf_inst <= inst_bus.inst_rdata;
              buf_pc   <= req_pc;
              state    <= HOLD;
            end
          end else if (live_taken) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (live_taken || id_allow_in_i) state <= ADV;
        end
      endcase
    end
  end

endmodule
